regfile_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 15-entry register file (r0–r14) and the PC write path. It shares the single register-file write port (we3/wa3/wd3) between two writeback requesters: requester 0, the ALU writeback, and requester 1, the load/store unit, which can issue multi-beat LDM bursts. Arbitration is round-robin with an optional burst lock. Each accepted write goes through one output register, and writes addressed to r15 are redirected to the PC write port.

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (req 0) and the LSU (req 1).
// Grants are round-robin, with an LSU burst lock. Writes to r15 are steered to the PC port.
module regfile_wb_arbiter #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          v0,
   input  logic [AW-1:0] a0,
   input  logic [DW-1:0] d0,
   output logic          r0,
   input  logic          v1,
   input  logic [AW-1:0] a1,
   input  logic [DW-1:0] d1,
   input  logic          lock1,
   output logic          r1,
   output logic          we3,
   output logic [AW-1:0] wa3,
   output logic [DW-1:0] wd3,
   output logic          pc_we,
   output logic [DW-1:0] pc_wd,
   output logic [14:0]   pending
);

   localparam logic [AW-1:0] PC_ADDR = '1;

   typedef enum logic {ST_RR, ST_LOCK1} state_e;

   state_e        state_q, state_d;
   logic          rr_q, rr_d;
   logic          gnt0, gnt1, hs;
   logic [AW-1:0] sel_a;
   logic [DW-1:0] sel_d;

   logic          we3_q, pc_we_q;
   logic [AW-1:0] wa3_q;
   logic [DW-1:0] wd3_q, pc_wd_q;

   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      state_d = state_q;
      rr_d    = rr_q;
      // Grant lines double as ready: reset and stall mask them combinationally
      if (!reset && !stall) begin
         unique case (state_q)
            ST_RR: begin
               if (v0 && v1) begin
                  gnt0 = !rr_q;
                  gnt1 = rr_q;
               end else begin
                  gnt0 = v0;
                  gnt1 = v1;
               end
            end
            ST_LOCK1: gnt1 = v1;
            default: ;
         endcase
      end
      if (gnt1) begin
         if (lock1) begin
            state_d = ST_LOCK1;
         end else begin
            state_d = ST_RR;
            rr_d    = 1'b0;
         end
      end else if (gnt0) begin
         rr_d = 1'b1;
      end
   end

   assign r0    = gnt0;
   assign r1    = gnt1;
   assign hs    = gnt0 | gnt1;
   assign sel_a = gnt1 ? a1 : a0;
   assign sel_d = gnt1 ? d1 : d0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RR;
         rr_q    <= 1'b0;
         we3_q   <= 1'b0;
         wa3_q   <= '0;
         wd3_q   <= '0;
         pc_we_q <= 1'b0;
         pc_wd_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         we3_q   <= hs && (sel_a != PC_ADDR);
         pc_we_q <= hs && (sel_a == PC_ADDR);
         if (hs && (sel_a != PC_ADDR)) begin
            wa3_q <= sel_a;
            wd3_q <= sel_d;
         end
         if (hs && (sel_a == PC_ADDR)) begin
            pc_wd_q <= sel_d;
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int unsigned i = 0; i < 15; i++) begin
         pending[i] = we3_q && (wa3_q == AW'(i));
      end
   end

   assign we3   = we3_q;
   assign wa3   = wa3_q;
   assign wd3   = wd3_q;
   assign pc_we = pc_we_q;
   assign pc_wd = pc_wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reference model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        reset, stall;
   logic        v0, v1, lock1;
   logic [3:0]  a0, a1;
   logic [31:0] d0, d1;
   logic        r0, r1, we3, pc_we;
   logic [3:0]  wa3;
   logic [31:0] wd3, pc_wd;
   logic [14:0] pending;

   int total = 0;
   int bad   = 0;

   regfile_wb_arbiter #(.DW(32), .AW(4)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .v0(v0), .a0(a0), .d0(d0), .r0(r0),
      .v1(v1), .a1(a1), .d1(d1), .lock1(lock1), .r1(r1),
      .we3(we3), .wa3(wa3), .wd3(wd3),
      .pc_we(pc_we), .pc_wd(pc_wd), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: expected registered outputs for the current cycle
   logic        m_lock = 1'b0;
   logic        m_prio = 1'b0;
   logic        m_we = 1'b0, m_pcwe = 1'b0;
   logic [3:0]  m_wa = '0;
   logic [31:0] m_wd = '0, m_pcwd = '0;

   always @(negedge clk) begin
      int          g;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [14:0] ep;
      g = -1;
      if (!reset && !stall) begin
         if (m_lock)         g = v1 ? 1 : -1;
         else if (v0 && v1)  g = m_prio ? 1 : 0;
         else if (v0)        g = 0;
         else if (v1)        g = 1;
      end
      ep = m_we ? 15'(32'd1 << m_wa) : 15'd0;
      chk("m_r0", r0, (g == 0));
      chk("m_r1", r1, (g == 1));
      chk("m_we3", we3, m_we);
      chk("m_wa3", wa3, m_wa);
      chk("m_wd3", wd3, m_wd);
      chk("m_pc_we", pc_we, m_pcwe);
      chk("m_pc_wd", pc_wd, m_pcwd);
      chk("m_pending", pending, ep);
      if (reset) begin
         m_lock = 0; m_prio = 0; m_we = 0; m_pcwe = 0;
         m_wa = '0; m_wd = '0; m_pcwd = '0;
      end else begin
         m_we = 0; m_pcwe = 0;
         if (g >= 0) begin
            addr = (g == 1) ? a1 : a0;
            data = (g == 1) ? d1 : d0;
            if (addr == 4'd15) begin
               m_pcwe = 1; m_pcwd = data;
            end else begin
               m_we = 1; m_wa = addr; m_wd = data;
            end
            if (g == 1 && lock1) m_lock = 1;
            else begin
               m_lock = 0;
               m_prio = (g == 1) ? 1'b0 : 1'b1;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] rr_seq [4];
      rr_seq = '{4'd1, 4'd2, 4'd1, 4'd2};
      reset = 1; stall = 0; lock1 = 0;
      v0 = 1; v1 = 1; a0 = 4'd1; a1 = 4'd2; d0 = 32'hA0; d1 = 32'hB1;

      // Reset held two cycles with both requesters valid
      cyc(); cyc();
      chk("rst_r0", r0, 0);
      chk("rst_r1", r1, 0);
      chk("rst_we3", we3, 0);
      chk("rst_pc_we", pc_we, 0);
      chk("rst_pending", pending, 0);
      chk("rst_wd3", wd3, 0);

      // Round-robin 0,1,0,1
      reset = 0;
      #1;
      chk("rr_first_r0", r0, 1);
      chk("rr_first_r1", r1, 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rr_we3", we3, 1);
         chk("rr_wa3", wa3, rr_seq[i]);
      end
      v0 = 0; v1 = 0;

      // Single requester-0 write hands priority to requester 1
      v0 = 1; a0 = 4'd10; d0 = 32'h10;
      cyc();
      chk("pre_wa3", wa3, 4'd10);

      // 3-beat LSU burst while ALU keeps requesting
      a0 = 4'd9; d0 = 32'h9;
      v1 = 1; a1 = 4'd4; d1 = 32'h44; lock1 = 1;
      #1;
      chk("b1_r0", r0, 0);
      chk("b1_r1", r1, 1);
      cyc();
      chk("b1_wa3", wa3, 4'd4);
      a1 = 4'd5; d1 = 32'h55; lock1 = 1;
      #1;
      chk("b2_r0", r0, 0);
      cyc();
      chk("b2_wa3", wa3, 4'd5);
      a1 = 4'd6; d1 = 32'h66; lock1 = 0;
      #1;
      chk("b3_r0", r0, 0);
      chk("b3_r1", r1, 1);
      cyc();
      chk("b3_wa3", wa3, 4'd6);
      chk("b3_wd3", wd3, 32'h66);
      v1 = 0;
      #1;
      chk("post_r0", r0, 1);
      cyc();
      chk("post_wa3", wa3, 4'd9);

      // Locked with v1 low: port idles, ALU stays blocked
      a0 = 4'd13; d0 = 32'hD;
      v1 = 1; a1 = 4'd11; d1 = 32'hB; lock1 = 1;
      #1;
      chk("lk_r1", r1, 1);
      cyc();
      chk("lk_wa3", wa3, 4'd11);
      v1 = 0;
      #1;
      chk("lk_idle_r0", r0, 0);
      cyc();
      chk("lk_idle_we3", we3, 0);
      v1 = 1; a1 = 4'd12; d1 = 32'hC; lock1 = 0;
      cyc();
      chk("lk_exit_wa3", wa3, 4'd12);
      v1 = 0;
      #1;
      chk("lk_after_r0", r0, 1);
      cyc();
      chk("lk_after_wa3", wa3, 4'd13);

      // PC redirect
      a0 = 4'd15; d0 = 32'h0000_0100;
      cyc();
      chk("pc_pc_we", pc_we, 1);
      chk("pc_pc_wd", pc_wd, 32'h100);
      chk("pc_we3", we3, 0);
      chk("pc_pending", pending, 0);
      chk("pc_wa3_hold", wa3, 4'd13);

      // Stall two cycles, then grant
      a0 = 4'd3; d0 = 32'h33; stall = 1;
      #1;
      chk("st_r0", r0, 0);
      cyc();
      chk("st_we3_a", we3, 0);
      cyc();
      chk("st_we3_b", we3, 0);
      stall = 0;
      #1;
      chk("st_r0_rel", r0, 1);
      cyc();
      chk("st_we3", we3, 1);
      chk("st_wa3", wa3, 4'd3);
      chk("st_pending", pending, 15'h0008);

      // Reset coincident with a handshake
      a0 = 4'd7; d0 = 32'h77; reset = 1;
      cyc();
      chk("rh_we3", we3, 0);
      chk("rh_pending", pending, 0);
      reset = 0; v0 = 0;

      // Reset mid-burst returns to RR with priority 0
      v1 = 1; a1 = 4'd8; d1 = 32'h88; lock1 = 1;
      cyc();
      chk("rb_wa3", wa3, 4'd8);
      reset = 1;
      cyc();
      chk("rb_we3", we3, 0);
      reset = 0; lock1 = 0;
      v0 = 1; a0 = 4'd1; d0 = 32'h11; a1 = 4'd2; d1 = 32'h22;
      #1;
      chk("rb_r0", r0, 1);
      chk("rb_r1", r1, 0);
      cyc();
      chk("rb_wa3_g0", wa3, 4'd1);

      // Same address from both requesters: arbitration order, later one lands last
      a0 = 4'd5; d0 = 32'hAAAA; a1 = 4'd5; d1 = 32'hBBBB;
      cyc();
      chk("sa_wd3_first", wd3, 32'hBBBB);
      cyc();
      chk("sa_wd3_second", wd3, 32'hAAAA);
      chk("sa_pending", pending, 15'h0020);
      v0 = 0; v1 = 0;

      // Stall and reset together: reset wins
      v0 = 1; a0 = 4'd2; stall = 1; reset = 1;
      cyc();
      chk("sr_wd3", wd3, 0);
      stall = 0; reset = 0; v0 = 0;
      repeat (3) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
